// File: rtl/pcpi_initiator_pkg.sv
// Shared state encoding, PCPI instruction constants and defaults for the
// CPU-side PCPI initiator.
package pcpi_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } pcpi_state_e;

  localparam logic [6:0] PCPI_OPCODE = 7'b0110011;
  localparam logic [6:0] PCPI_FUNCT7 = 7'b0000001;

  typedef enum logic [2:0] {
    PCPI_OP_MUL    = 3'b000,
    PCPI_OP_MULH   = 3'b001,
    PCPI_OP_MULHSU = 3'b010,
    PCPI_OP_MULHU  = 3'b011,
    PCPI_OP_DIV    = 3'b100
  } pcpi_funct3_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int DEFAULT_CNT_W          = 16;

  // True when the word decodes as one of the co-processor operations.
  function automatic logic is_pcpi_insn(input logic [31:0] insn);
    return (insn[6:0] == PCPI_OPCODE) && (insn[31:25] == PCPI_FUNCT7) &&
           (insn[14:12] <= 3'b100);
  endfunction

endpackage

// File: rtl/pcpi_initiator_timeout_counter.sv
// Abort timer for an outstanding PCPI request: loaded on issue, reloaded while
// the co-processor signals busy, and flags expiry on the last silent cycle.
module pcpi_initiator_timeout_counter
  import pcpi_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic run,
  input  logic busy,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_s;
      assign unused_s = ^{clk, rst, load, run, busy};
      assign expired  = 1'b0;
    end else begin : g_on
      localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES);
      localparam logic [CW-1:0] LAST_VAL = CW'(1);

      logic [CW-1:0] cnt_r;

      // Remaining silent cycles before the request is abandoned
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_r <= {CW{1'b0}};
        end else if (load || (run && busy)) begin
          cnt_r <= LOAD_VAL;
        end else if (run && (cnt_r != {CW{1'b0}})) begin
          cnt_r <= cnt_r - LAST_VAL;
        end else begin
          cnt_r <= cnt_r;
        end
      end

      // A busy cycle restarts the budget, so it can never be the expiring one.
      assign expired = run && !busy && (cnt_r == LAST_VAL);
    end
  endgenerate

endmodule

// File: rtl/pcpi_initiator.sv
// CPU-side PCPI initiator: takes one host command, drives the PCPI request,
// returns the co-processor result (or a timeout) and keeps saturating statistics.
module pcpi_initiator
  import pcpi_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_insn,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  output logic             pico_valid,
  output logic [31:0]      pico_insn,
  output logic [31:0]      pico_rs1,
  output logic [31:0]      pico_rs2,
  input  logic             pico_wr,
  input  logic [31:0]      pico_rd,
  input  logic             pico_wait,
  input  logic             pico_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_wr,
  output logic [31:0]      rsp_data,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] cnt_done,
  output logic [CNT_W-1:0] cnt_tmo
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  pcpi_state_e state_r;
  pcpi_state_e next_state_s;
  logic        accept_s;
  logic        complete_s;
  logic        abort_s;
  logic        expired_s;

  pcpi_initiator_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (accept_s),
    .run    (state_r == ST_ISSUE),
    .busy   (pico_wait),
    .expired(expired_s)
  );

  // Next-state and event decode; pico_ready takes priority over expiry
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_s     = 1'b1;
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (pico_ready) begin
          complete_s   = 1'b1;
          next_state_s = ST_RESP;
        end else if (expired_s) begin
          abort_s      = 1'b1;
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Handshake flags are registered copies of the state being entered, so
  // pico_valid drops on the same edge that samples pico_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready  <= 1'b0;
      pico_valid <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      cmd_ready  <= (next_state_s == ST_IDLE);
      pico_valid <= (next_state_s == ST_ISSUE);
      rsp_valid  <= (next_state_s == ST_RESP);
    end
  end

  // Request payload, held stable for the whole ISSUE phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pico_insn <= 32'h0000_0000;
      pico_rs1  <= 32'h0000_0000;
      pico_rs2  <= 32'h0000_0000;
    end else if (accept_s) begin
      pico_insn <= cmd_insn;
      pico_rs1  <= cmd_rs1;
      pico_rs2  <= cmd_rs2;
    end else begin
      pico_insn <= pico_insn;
      pico_rs1  <= pico_rs1;
      pico_rs2  <= pico_rs2;
    end
  end

  // Response capture; rd is only meaningful when the co-processor writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_wr      <= 1'b0;
      rsp_data    <= 32'h0000_0000;
      rsp_timeout <= 1'b0;
    end else if (complete_s) begin
      rsp_wr      <= pico_wr;
      rsp_data    <= pico_wr ? pico_rd : 32'h0000_0000;
      rsp_timeout <= 1'b0;
    end else if (abort_s) begin
      rsp_wr      <= 1'b0;
      rsp_data    <= 32'h0000_0000;
      rsp_timeout <= 1'b1;
    end else begin
      rsp_wr      <= rsp_wr;
      rsp_data    <= rsp_data;
      rsp_timeout <= rsp_timeout;
    end
  end

  // Saturating completion / timeout statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_done <= {CNT_W{1'b0}};
      cnt_tmo  <= {CNT_W{1'b0}};
    end else begin
      if (complete_s && (cnt_done != CNT_MAX)) begin
        cnt_done <= cnt_done + CNT_ONE;
      end else begin
        cnt_done <= cnt_done;
      end
      if (abort_s && (cnt_tmo != CNT_MAX)) begin
        cnt_tmo <= cnt_tmo + CNT_ONE;
      end else begin
        cnt_tmo <= cnt_tmo;
      end
    end
  end

endmodule

// File: tb/tb_pcpi_initiator.sv
// Self-checking bench for pcpi_initiator: transaction-level reference model,
// per-cycle compare process and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_pcpi_initiator;

  localparam int TMO = 8;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_insn = 32'h0, cmd_rs1 = 32'h0, cmd_rs2 = 32'h0;
  logic          pico_valid;
  logic [31:0]   pico_insn, pico_rs1, pico_rs2;
  logic          pico_wr = 1'b0;
  logic [31:0]   pico_rd = 32'h0;
  logic          pico_wait = 1'b0;
  logic          pico_ready = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_wr;
  logic [31:0]   rsp_data;
  logic          rsp_timeout;
  logic [CW-1:0] cnt_done, cnt_tmo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pcpi_initiator #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_insn(cmd_insn), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .pico_valid(pico_valid), .pico_insn(pico_insn), .pico_rs1(pico_rs1), .pico_rs2(pico_rs2),
    .pico_wr(pico_wr), .pico_rd(pico_rd), .pico_wait(pico_wait), .pico_ready(pico_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .cnt_done(cnt_done), .cnt_tmo(cnt_tmo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: phase 0 = waiting for a command, 1 = request outstanding,
  // 2 = response held for the host. Silence counts cycles without pico_wait.
  int          m_phase, m_silent, m_done, m_tmo;
  bit          m_seen;
  logic [31:0] m_insn, m_rs1, m_rs2, m_data;
  logic        m_wr, m_to;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_silent <= 0; m_done <= 0; m_tmo <= 0; m_seen <= 1'b0;
      m_insn <= 32'h0; m_rs1 <= 32'h0; m_rs2 <= 32'h0;
      m_data <= 32'h0; m_wr <= 1'b0; m_to <= 1'b0;
    end else begin
      m_seen <= 1'b1;
      if (m_phase == 0) begin
        if (cmd_valid && m_seen) begin
          m_phase <= 1; m_silent <= 0;
          m_insn <= cmd_insn; m_rs1 <= cmd_rs1; m_rs2 <= cmd_rs2;
        end
      end else if (m_phase == 1) begin
        if (pico_ready) begin
          m_wr <= pico_wr; m_data <= pico_wr ? pico_rd : 32'h0; m_to <= 1'b0;
          m_done <= m_done + 1; m_phase <= 2;
        end else if (pico_wait) begin
          m_silent <= 0;
        end else if (TMO != 0 && m_silent + 1 >= TMO) begin
          m_wr <= 1'b0; m_data <= 32'h0; m_to <= 1'b1;
          m_tmo <= m_tmo + 1; m_phase <= 2;
        end else begin
          m_silent <= m_silent + 1;
        end
      end else if (rsp_ready) begin
        m_phase <= 0;
      end
    end
  end

  // Compare process plus a check that requests are separated by an idle cycle
  int gap = 1;
  bit prev_pv = 1'b0, seen_req = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      gap <= 1; prev_pv <= 1'b0; seen_req <= 1'b0;
    end else begin
      chk("cmd_ready",   cmd_ready,   (m_phase == 0) && m_seen);
      chk("pico_valid",  pico_valid,  m_phase == 1);
      chk("rsp_valid",   rsp_valid,   m_phase == 2);
      chk("pico_insn",   pico_insn,   m_insn);
      chk("pico_rs1",    pico_rs1,    m_rs1);
      chk("pico_rs2",    pico_rs2,    m_rs2);
      chk("rsp_wr",      rsp_wr,      m_wr);
      chk("rsp_data",    rsp_data,    m_data);
      chk("rsp_timeout", rsp_timeout, m_to);
      chk("cnt_done",    cnt_done,    (m_done > SAT) ? SAT : m_done);
      chk("cnt_tmo",     cnt_tmo,     (m_tmo > SAT) ? SAT : m_tmo);
      if (pico_valid && !prev_pv && seen_req) chk("req_gap", gap >= 1, 1);
      gap <= pico_valid ? 0 : gap + 1;
      prev_pv <= pico_valid;
      if (pico_valid) seen_req <= 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    bit ok = 1'b0;
    cmd_insn = insn; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1'b1;
    end
    chk("cmd_accept_wait", ok, 1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input int n, input logic wr, input logic [31:0] rd);
    tick(n);
    pico_ready = 1'b1; pico_wr = wr; pico_rd = rd;
    tick(1);
    pico_ready = 1'b0; pico_wr = 1'b0; pico_rd = 32'h0;
  endtask

  task automatic take_rsp(input int hold);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rsp_valid) ok = 1'b1;
      else tick(1);
    end
    chk("rsp_wait", ok, 1);
    if (hold > 0) tick(hold);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    chk("post_reset_cnt_done", cnt_done, 0);
    chk("post_reset_cnt_tmo", cnt_tmo, 0);

    // pico_ready while idle must be ignored
    pico_ready = 1'b1; pico_wr = 1'b1; pico_rd = 32'h1234;
    tick(1);
    pico_ready = 1'b0; pico_wr = 1'b0; pico_rd = 32'h0;
    tick(1);
    chk("idle_ready_ignored", cnt_done, 0);

    // Normal completion, ready sampled five edges after the command edge
    send_cmd(32'h0200_0033, 32'h3C00_4000, 32'h0000_0011);
    chk("issue_pico_valid", pico_valid, 1);
    chk("issue_pico_insn", pico_insn, 32'h0200_0033);
    chk("issue_pico_rs1", pico_rs1, 32'h3C00_4000);
    respond(4, 1'b1, 32'h0000_4200);
    chk("norm_rsp_valid", rsp_valid, 1);
    chk("norm_pico_valid_low", pico_valid, 0);
    chk("norm_rsp_wr", rsp_wr, 1);
    chk("norm_rsp_data", rsp_data, 32'h0000_4200);
    chk("norm_rsp_timeout", rsp_timeout, 0);
    chk("norm_cnt_done", cnt_done, 1);
    pico_ready = 1'b1;
    tick(1);
    pico_ready = 1'b0;
    chk("resp_ready_ignored", cnt_done, 1);
    take_rsp(0);

    // Silent responder: exactly TMO request cycles, then abort
    send_cmd(32'h0200_4033, 32'h1, 32'h2);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pico_valid) cnt++;
      else break;
    end
    chk("tmo_issue_cycles", cnt, 8);
    chk("tmo_rsp_timeout", rsp_timeout, 1);
    chk("tmo_rsp_data", rsp_data, 32'h0);
    chk("tmo_cnt_tmo", cnt_tmo, 1);
    take_rsp(0);

    // Busy co-processor holds off the timeout
    pico_wait = 1'b1;
    send_cmd(32'h0200_5033, 32'h3, 32'h4);
    tick(20);
    chk("wait_pico_valid", pico_valid, 1);
    chk("wait_no_rsp", rsp_valid, 0);
    pico_wait = 1'b0;
    respond(3, 1'b1, 32'hCAFE_0001);
    chk("wait_rsp_timeout", rsp_timeout, 0);
    chk("wait_cnt_done", cnt_done, 2);
    take_rsp(0);

    // Back-pressure: response stable, new commands refused
    send_cmd(32'h0200_6033, 32'h5, 32'h6);
    respond(2, 1'b1, 32'h0000_A5A5);
    cmd_insn = 32'hFFFF_FFFF; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_rsp_data", rsp_data, 32'h0000_A5A5);
    end
    cmd_valid = 1'b0;
    take_rsp(0);
    chk("bp_cnt_done", cnt_done, 3);

    // Back-to-back commands; counter saturates at 3
    send_cmd(32'h0200_7033, 32'h7, 32'h8);
    respond(1, 1'b1, 32'h0000_0B0B);
    take_rsp(0);
    send_cmd(32'h0200_0033, 32'h9, 32'hA);
    respond(1, 1'b1, 32'h0000_0C0C);
    take_rsp(0);
    chk("sat_cnt_done", cnt_done, 3);

    // wr=0 masks rd; rsp_ready held high across the whole transaction
    rsp_ready = 1'b1;
    send_cmd(32'h0200_1033, 32'hB, 32'hC);
    respond(2, 1'b0, 32'hDEAD_BEEF);
    chk("nowr_rsp_wr", rsp_wr, 0);
    chk("nowr_rsp_data", rsp_data, 32'h0);
    tick(1);
    chk("nowr_rsp_taken", rsp_valid, 0);
    rsp_ready = 1'b0;

    // pico_ready on the expiry cycle completes normally
    send_cmd(32'h0200_2033, 32'hD, 32'hE);
    respond(7, 1'b1, 32'h0000_0077);
    chk("race_rsp_timeout", rsp_timeout, 0);
    chk("race_rsp_data", rsp_data, 32'h0000_0077);
    chk("race_cnt_tmo", cnt_tmo, 1);
    take_rsp(0);

    // Asynchronous reset in the middle of a request
    send_cmd(32'h0200_3033, 32'hF, 32'h10);
    tick(2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_pico_valid", pico_valid, 0);
    chk("async_rst_cnt_done", cnt_done, 0);
    chk("async_rst_cnt_tmo", cnt_tmo, 0);
    chk("async_rst_cmd_ready", cmd_ready, 0);
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("rel_cmd_ready", cmd_ready, 1);

    // Five completions into a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      send_cmd(32'h0200_0033, 32'(i), 32'(i + 1));
      respond(1, 1'b1, 32'(i * 3));
      take_rsp(0);
    end
    chk("five_cnt_done", cnt_done, 3);
    chk("five_cnt_tmo", cnt_tmo, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
